// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants and helper functions for the runtime
//                configurable serial pattern detector.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Output mode encoding (cfg_moore)
    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;

    // Bit arrival order encoding (cfg_lsb_first)
    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

    // Widest pattern the helpers handle; MAX_LEN of any instance must not exceed it
    localparam int c_PAT_W_MAX = 32;
    localparam int c_LEN_W_MAX = 6;

    // Reverse the low 'len' bits of 'pattern'; bits at and above 'len' are zero.
    function automatic logic [c_PAT_W_MAX-1:0] bitrev_len(
        input logic [c_PAT_W_MAX-1:0] pattern,
        input logic [c_LEN_W_MAX-1:0] len
    );
        logic [c_PAT_W_MAX-1:0] rev;
        int                     src;
        rev = '0;
        for (int i = 0; i < c_PAT_W_MAX; i++) begin
            if (i < int'(len)) begin
                src    = int'(len) - 1 - i;
                rev[i] = pattern[src[4:0]];
            end
        end
        return rev;
    endfunction

    // Mask with the low 'len' bits set.
    function automatic logic [c_PAT_W_MAX-1:0] len_mask(
        input logic [c_LEN_W_MAX-1:0] len
    );
        logic [c_PAT_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < c_PAT_W_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_window_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_window_cmp
//  Description : Combinational comparison of the most recent 'len' received
//                bits (current bit as LSB) against the configured pattern,
//                reversed first when the pattern is sent LSB-first.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_window_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-2:0] hist,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               lsb_first,
    output logic               window_eq
);

    logic [MAX_LEN-1:0]     w_window;
    logic [c_PAT_W_MAX-1:0] w_window_ext;
    logic [c_PAT_W_MAX-1:0] w_pattern_ext;
    logic [c_PAT_W_MAX-1:0] w_expected;
    logic [c_PAT_W_MAX-1:0] w_mask;
    logic [c_LEN_W_MAX-1:0] w_len_ext;

    // Oldest bit lands in the MSB, so an MSB-first pattern compares directly.
    assign w_window      = {hist, x};
    assign w_window_ext  = c_PAT_W_MAX'(w_window);
    assign w_pattern_ext = c_PAT_W_MAX'(pattern);
    assign w_len_ext     = c_LEN_W_MAX'(len);

    // Select the expected window value and compare only the low 'len' bits.
    always_comb begin
        w_expected = w_pattern_ext;
        if (lsb_first == ORDER_LSB) begin
            w_expected = bitrev_len(w_pattern_ext, w_len_ext);
        end
        w_mask    = len_mask(w_len_ext);
        window_eq = (((w_window_ext ^ w_expected) & w_mask) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Runtime-configurable serial bit-pattern detector with
//                overlap / non-overlap, Moore / Mealy output, MSB/LSB-first
//                ordering, input qualifier and saturating match counter.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    input  logic               cfg_lsb_first,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    localparam int               c_HIST_W  = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(MAX_LEN);

    // Configuration registers
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_moore;
    logic               r_lsb_first;

    // Detection state
    logic [c_HIST_W-1:0] r_hist;
    logic [LEN_W-1:0]    r_fill;
    logic                r_y;
    logic [CNT_W-1:0]    r_count;

    logic               w_accept;
    logic               w_window_eq;
    logic               w_filled;
    logic               w_match;
    logic [LEN_W-1:0]   w_cfg_len;

    // A bit arriving alongside cfg_load is dropped: the load restarts history.
    assign w_accept  = in_valid & ~cfg_load;

    // Enough bits seen (including the current one) to fill the window.
    assign w_filled  = (({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len});

    assign w_match   = w_accept & (r_len != '0) & w_filled & w_window_eq;

    // Oversized lengths collapse to the largest supported window.
    assign w_cfg_len = (cfg_len > c_LEN_MAX) ? c_LEN_MAX : cfg_len;

    seq_window_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window_cmp (
        .hist      (r_hist),
        .x         (x),
        .pattern   (r_pattern),
        .len       (r_len),
        .lsb_first (r_lsb_first),
        .window_eq (w_window_eq)
    );

    // Configuration latch: only updated on reset or an explicit load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern   <= '0;
            r_len       <= '0;
            r_overlap   <= 1'b1;
            r_moore     <= MODE_MOORE;
            r_lsb_first <= ORDER_MSB;
        end else if (cfg_load) begin
            r_pattern   <= cfg_pattern;
            r_len       <= w_cfg_len;
            r_overlap   <= cfg_overlap;
            r_moore     <= cfg_moore;
            r_lsb_first <= cfg_lsb_first;
        end
    end

    // Shift history, track fill level and register the Moore output per accepted bit.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (w_accept) begin
            r_hist <= c_HIST_W'({r_hist, x});
            r_y    <= w_match;
            if (w_match && !r_overlap) begin
                // Non-overlapping: the next match must be built from fresh bits.
                r_fill <= '0;
            end else if (r_fill != c_LEN_MAX) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

    // Saturating match counter; clear has priority over a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst || cfg_load || cnt_clr) begin
            r_count <= '0;
        end else if (w_match && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Output select; forced low while reset is asserted.
    assign y           = ~rst & ((r_moore == MODE_MOORE) ? r_y : w_match);
    assign match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Directed self-checking bench for seq_detector_param.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst;
    logic               x;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               cfg_lsb_first;
    logic               cnt_clr;
    logic               y;
    logic [CNT_W-1:0]   match_count;
    logic               y_sat;
    logic [1:0]         match_count_sat;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_moore(cfg_moore), .cfg_lsb_first(cfg_lsb_first), .cnt_clr(cnt_clr),
        .y(y), .match_count(match_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_moore(cfg_moore), .cfg_lsb_first(cfg_lsb_first), .cnt_clr(cnt_clr),
        .y(y_sat), .match_count(match_count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one accepted bit; y is sampled mid-cycle before the capturing edge.
    task automatic send(input logic b, input logic exp_y, input string tag);
        x        = b;
        in_valid = 1'b1;
        #2;
        chk(tag, 32'(y), 32'(exp_y));
        tick();
        in_valid = 1'b0;
    endtask

    // One cycle with in_valid low and a toggling x that must be ignored.
    task automatic idle(input logic exp_y, input string tag);
        in_valid = 1'b0;
        x        = ~x;
        #2;
        chk(tag, 32'(y), 32'(exp_y));
        tick();
    endtask

    // Send n bits, listed in arrival order from bit n-1 of 'bits' downward.
    task automatic run(input logic [15:0] bits, input logic [15:0] exp, input int n,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], exp[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
        end
    endtask

    // Load a configuration, then scramble the cfg pins to show they are ignored.
    task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov, input logic moore, input logic lsb);
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_overlap   = ov;
        cfg_moore     = moore;
        cfg_lsb_first = lsb;
        cfg_load      = 1'b1;
        in_valid      = 1'b0;
        tick();
        cfg_load      = 1'b0;
        cfg_pattern   = ~pat;
        cfg_len       = '0;
        cfg_overlap   = ~ov;
        cfg_moore     = ~moore;
        cfg_lsb_first = ~lsb;
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_moore = 1'b0;
        cfg_lsb_first = 1'b0;

        // Reset state
        tick();
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        tick();
        rst = 1'b0;
        chk("post_rst_y", 32'(y), 32'd0);
        run(16'b1010, 16'b0000, 4, "len0_after_rst");
        chk("len0_after_rst_cnt", 32'(match_count), 32'd0);

        // 1010 MSB-first, overlap, Moore
        cfg(8'b1010, 4'd4, 1'b1, 1'b1, 1'b0);
        run(16'b1010101, 16'b0000101, 7, "moore_ov");
        idle(1'b0, "moore_ov_tail");
        chk("moore_ov_cnt", 32'(match_count), 32'd2);

        // Same stream, non-overlapping
        cfg(8'b1010, 4'd4, 1'b0, 1'b1, 1'b0);
        run(16'b1010101, 16'b0000100, 7, "moore_nov");
        idle(1'b0, "moore_nov_tail");
        chk("moore_nov_cnt", 32'(match_count), 32'd1);

        // 1101 LSB-first (arrives 1,0,1,1), Mealy, overlap
        cfg(8'b1101, 4'd4, 1'b1, 1'b0, 1'b1);
        run(16'b1011011, 16'b0001001, 7, "mealy_lsb");
        idle(1'b0, "mealy_lsb_tail");
        chk("mealy_lsb_cnt", 32'(match_count), 32'd2);

        // Moore output holds through in_valid gaps
        cfg(8'b1010, 4'd4, 1'b1, 1'b1, 1'b0);
        run(16'b1010, 16'b0000, 4, "gap");
        idle(1'b1, "gap_hold1");
        idle(1'b1, "gap_hold2");
        idle(1'b1, "gap_hold3");
        send(1'b1, 1'b1, "gap_next_bit");
        idle(1'b0, "gap_drop");
        chk("gap_cnt", 32'(match_count), 32'd1);

        // Five Mealy matches: wide counter 5, 2-bit counter saturates at 3
        cfg(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0);
        run(16'b101010101010, 16'b000101010101, 12, "sat");
        chk("sat_cnt_wide", 32'(match_count), 32'd5);
        chk("sat_cnt_narrow", 32'(match_count_sat), 32'd3);
        send(1'b1, 1'b0, "clr_pre");
        cnt_clr = 1'b1;
        send(1'b0, 1'b1, "clr_match_y");
        cnt_clr = 1'b0;
        chk("clr_cnt_wide", 32'(match_count), 32'd0);
        chk("clr_cnt_narrow", 32'(match_count_sat), 32'd0);
        run(16'b10, 16'b01, 2, "after_clr");
        chk("after_clr_cnt", 32'(match_count), 32'd1);

        // len = 0 never matches
        cfg(8'b1010, 4'd0, 1'b1, 1'b0, 1'b0);
        run(16'b1010, 16'b0000, 4, "len0");
        chk("len0_cnt", 32'(match_count), 32'd0);

        // Oversized length clamps to MAX_LEN
        cfg(8'b10110011, 4'd11, 1'b1, 1'b0, 1'b0);
        run(16'b10110011, 16'b00000001, 8, "clamp");
        chk("clamp_cnt", 32'(match_count), 32'd1);

        // cfg_load coinciding with a completing bit
        cfg(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0);
        run(16'b10101, 16'b00010, 5, "ldhit_pre");
        chk("ldhit_pre_cnt", 32'(match_count), 32'd1);
        cfg_pattern = 8'b1010; cfg_len = 4'd4; cfg_overlap = 1'b1;
        cfg_moore = 1'b0; cfg_lsb_first = 1'b0;
        cfg_load = 1'b1; x = 1'b0; in_valid = 1'b1;
        #2;
        chk("ldhit_y", 32'(y), 32'd0);
        tick();
        cfg_load = 1'b0; in_valid = 1'b0;
        chk("ldhit_cnt", 32'(match_count), 32'd0);
        run(16'b01010, 16'b00001, 5, "ldhit_post");
        chk("ldhit_post_cnt", 32'(match_count), 32'd1);

        // Reset mid-stream clears config and history
        cfg(8'b1010, 4'd4, 1'b1, 1'b1, 1'b0);
        run(16'b101, 16'b000, 3, "mid_rst_pre");
        rst = 1'b1; in_valid = 1'b0;
        #2;
        chk("mid_rst_y", 32'(y), 32'd0);
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(match_count), 32'd0);
        send(1'b0, 1'b0, "mid_rst_b4");
        idle(1'b0, "mid_rst_tail");
        run(16'b1010, 16'b0000, 4, "mid_rst_len0");
        idle(1'b0, "mid_rst_len0_tail");
        chk("mid_rst_len0_cnt", 32'(match_count), 32'd0);
        cfg(8'b1010, 4'd4, 1'b1, 1'b1, 1'b0);
        run(16'b1010, 16'b0000, 4, "reload");
        idle(1'b1, "reload_y");
        chk("reload_cnt", 32'(match_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
